alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_iter.sv | 73 +++++++
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared codes and types for the sequential ALU: unit/function encodings,
// controller states and the registered flag bundle.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADDSUB = 4'd0;
    localparam logic [3:0] OP_SHIFT  = 4'd1;
    localparam logic [3:0] OP_LOGIC  = 4'd2;
    localparam logic [3:0] OP_MUL    = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;

    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_INC = 4'd1;
    localparam logic [3:0] F_SUB = 4'd2;
    localparam logic [3:0] F_DEC = 4'd3;

    localparam logic [3:0] F_SHL = 4'd0;
    localparam logic [3:0] F_SHR = 4'd1;
    localparam logic [3:0] F_SAR = 4'd2;
    localparam logic [3:0] F_SAL = 4'd3;

    localparam logic [3:0] F_AND = 4'd0;
    localparam logic [3:0] F_OR  = 4'd1;
    localparam logic [3:0] F_XOR = 4'd2;
    localparam logic [3:0] F_NOR = 4'd3;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    typedef struct packed {
        logic carryout;
        logic overflow;
        logic zero;
        logic n;
        logic dz;
    } flags_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Radix-2 multiply/divide datapath: shift-add multiply and restoring divide
// sharing one {hi, lo} register pair. result is the value after the current step.
module alu_seq_iter import alu_seq_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi, lo, dvs;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   rem_sh;
    logic [CW-1:0]    cnt;

    // mode=1: restoring divide, hi = partial remainder, lo = dividend/quotient.
    // mode=0: shift-add multiply, lo = multiplier shifting out as product bits shift in.
    always_comb begin
        acc    = '0;
        rem_sh = '0;
        hi_nxt = hi;
        lo_nxt = lo;
        if (mode) begin
            rem_sh = {hi, lo[WIDTH-1]};
            if (rem_sh >= {1'b0, dvs}) begin
                acc    = rem_sh - {1'b0, dvs};
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                acc    = rem_sh;
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
            hi_nxt = acc[WIDTH-1:0];
        end else begin
            acc    = {1'b0, hi} + ({(WIDTH+1){lo[0]}} & {1'b0, dvs});
            hi_nxt = acc[WIDTH:1];
            lo_nxt = {acc[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WIDTH);
        end else if (step && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hi  <= '0;
            lo  <= a;
            dvs <= b;
        end else if (step) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

    assign last   = (cnt == CW'(1));
    assign result = {hi_nxt, lo_nxt};

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle add/sub, shift and logic units plus iterative
// unsigned multiply/divide, with a start/busy/done handshake.
module alu_seq import alu_seq_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [3:0]           op1,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out,
    output logic                 carryout,
    output logic                 overflow,
    output logic                 zero,
    output logic                 N,
    output logic                 dz
);

    state_t state, state_nxt;
    flags_t flags_q, sc_flags, it_flags;

    logic                 div_q, dz_q;
    logic                 it_load, it_step, it_last, is_iter;
    logic [2*WIDTH-1:0]   it_result;

    logic [WIDTH-1:0]     sc_res, opb;
    logic                 sc_c, sc_v, sub;
    logic [WIDTH:0]       add_ext, shl_t, shr_t;
    logic signed [WIDTH:0] sar_src;
    logic [SHW-1:0]       s;

    assign s       = in1[SHW-1:0];
    assign sar_src = {in0, 1'b0};
    assign is_iter = (op == OP_MUL) || (op == OP_DIV);

    // Single-cycle units; shifts run one bit wider so the last bit out lands in the extra bit.
    always_comb begin
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sub     = 1'b0;
        opb     = in1;
        add_ext = '0;
        shl_t   = '0;
        shr_t   = '0;
        case (op)
            OP_ADDSUB: begin
                sub = (op1 == F_SUB) || (op1 == F_DEC);
                if ((op1 == F_INC) || (op1 == F_DEC)) opb = WIDTH'(1);
                if (sub) begin
                    add_ext = {1'b0, in0} - {1'b0, opb};
                    sc_v    = (in0[WIDTH-1] != opb[WIDTH-1]) && (add_ext[WIDTH-1] != in0[WIDTH-1]);
                end else begin
                    add_ext = {1'b0, in0} + {1'b0, opb};
                    sc_v    = (in0[WIDTH-1] == opb[WIDTH-1]) && (add_ext[WIDTH-1] != in0[WIDTH-1]);
                end
                sc_res = add_ext[WIDTH-1:0];
                sc_c   = add_ext[WIDTH];
            end
            OP_SHIFT: begin
                case (op1)
                    F_SHR: begin
                        shr_t  = {in0, 1'b0} >> s;
                        sc_res = shr_t[WIDTH:1];
                        sc_c   = shr_t[0];
                    end
                    F_SAR: begin
                        shr_t  = sar_src >>> s;
                        sc_res = shr_t[WIDTH:1];
                        sc_c   = shr_t[0];
                    end
                    default: begin
                        shl_t  = {1'b0, in0} << s;
                        sc_res = shl_t[WIDTH-1:0];
                        sc_c   = shl_t[WIDTH];
                    end
                endcase
            end
            OP_LOGIC: begin
                case (op1)
                    F_OR:    sc_res = in0 | in1;
                    F_XOR:   sc_res = in0 ^ in1;
                    F_NOR:   sc_res = ~(in0 | in1);
                    default: sc_res = in0 & in1;
                endcase
            end
            default: ;
        endcase
        sc_flags          = '0;
        sc_flags.carryout = sc_c;
        sc_flags.overflow = sc_v;
        sc_flags.zero     = (sc_res == '0);
        sc_flags.n        = sc_res[WIDTH-1];
    end

    always_comb begin
        it_flags = '0;
        if (div_q) begin
            it_flags.dz   = dz_q;
            it_flags.n    = it_result[WIDTH-1];
            it_flags.zero = (it_result[WIDTH-1:0] == '0);
        end else begin
            it_flags.overflow = |it_result[2*WIDTH-1:WIDTH];
            it_flags.n        = it_result[2*WIDTH-1];
            it_flags.zero     = (it_result == '0);
        end
    end

    always_comb begin
        state_nxt = state;
        it_load   = 1'b0;
        it_step   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_iter) begin
                        it_load   = 1'b1;
                        state_nxt = ITER;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            ITER: begin
                it_step = 1'b1;
                if (it_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out and flags change only when DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out     <= '0;
            flags_q <= '0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                div_q <= (op == OP_DIV);
                dz_q  <= (in1 == '0);
                if (!is_iter) begin
                    out     <= {{WIDTH{1'b0}}, sc_res};
                    flags_q <= sc_flags;
                end
            end else if (state == ITER && it_last) begin
                out     <= it_result;
                flags_q <= it_flags;
            end
        end
    end

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (it_load),
        .step   (it_step),
        .mode   (div_q),
        .a      (in0),
        .b      (in1),
        .last   (it_last),
        .result (it_result)
    );

    assign busy     = (state == ITER);
    assign done     = (state == DONE);
    assign carryout = flags_q.carryout;
    assign overflow = flags_q.overflow;
    assign zero     = flags_q.zero;
    assign N        = flags_q.n;
    assign dz       = flags_q.dz;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): directed vector table, handshake and reset
// sequences, then random operations against a plain-arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0, op1 = '0;
    logic [31:0] in0 = '0, in1 = '0;
    logic        busy, done, carryout, overflow, zero, N, dz;
    logic [63:0] out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op1(op1),
        .in0(in0), .in1(in1), .busy(busy), .done(done), .out(out),
        .carryout(carryout), .overflow(overflow), .zero(zero), .N(N), .dz(dz)
    );

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  op1;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic [4:0]  fl;   // {carryout, overflow, zero, N, dz}
        int          lat;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] o_op, input logic [3:0] o_op1,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] r, output logic [4:0] fl,
                          output int lat, output int bcnt);
        @(negedge clk);
        op = o_op; op1 = o_op1; in0 = a; in1 = b; start = 1'b1;
        lat = 0; bcnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        r  = out;
        fl = {carryout, overflow, zero, N, dz};
    endtask

    // Reference behaviour straight from the arithmetic definitions.
    task automatic model(input logic [3:0] m_op, input logic [3:0] m_op1,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] r, output logic [4:0] fl, output int lat);
        logic [31:0] bb, q, rm;
        logic [63:0] wide;
        longint      sr;
        int          sh;
        logic        c, v, z, n, d;
        c = 0; v = 0; z = 0; n = 0; d = 0; r = '0; lat = 1;
        sh = int'(b[4:0]);
        case (m_op)
            4'd0: begin
                bb = (m_op1 == 4'd1 || m_op1 == 4'd3) ? 32'd1 : b;
                if (m_op1 == 4'd2 || m_op1 == 4'd3) begin
                    r  = {32'd0, a - bb};
                    c  = (a < bb);
                    sr = longint'($signed(a)) - longint'($signed(bb));
                end else begin
                    wide = {32'd0, a} + {32'd0, bb};
                    r    = {32'd0, wide[31:0]};
                    c    = wide[32];
                    sr   = longint'($signed(a)) + longint'($signed(bb));
                end
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                if (m_op1 == 4'd1) begin
                    r = {32'd0, a >> sh};
                    c = (sh == 0) ? 1'b0 : a[sh-1];
                end else if (m_op1 == 4'd2) begin
                    r = {32'd0, 32'($signed(a) >>> sh)};
                    c = (sh == 0) ? 1'b0 : a[sh-1];
                end else begin
                    r = {32'd0, a << sh};
                    c = (sh == 0) ? 1'b0 : a[32-sh];
                end
            end
            4'd2: begin
                if (m_op1 == 4'd1)      r = {32'd0, a | b};
                else if (m_op1 == 4'd2) r = {32'd0, a ^ b};
                else if (m_op1 == 4'd3) r = {32'd0, ~(a | b)};
                else                    r = {32'd0, a & b};
            end
            4'd3: begin
                r   = {32'd0, a} * {32'd0, b};
                v   = (r[63:32] != 0);
                lat = 33;
            end
            4'd4: begin
                if (b == 0) begin q = 32'hFFFF_FFFF; rm = a; d = 1; end
                else begin q = a / b; rm = a % b; end
                r   = {rm, q};
                lat = 33;
            end
            default: r = '0;
        endcase
        if (m_op == 4'd3)      begin n = r[63]; z = (r == 0); end
        else if (m_op == 4'd4) begin n = r[31]; z = (r[31:0] == 0); end
        else                   begin n = r[31]; z = (r[31:0] == 0); end
        fl = {c, v, z, n, d};
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    logic [63:0] r, er;
    logic [4:0]  fl, efl;
    int          lat, elat, bcnt;
    logic [3:0]  rop, rop1;
    logic [31:0] ra, rb;
    bit          seen;

    initial begin
        tbl[0]  = '{4'd0, 4'd0, 32'h7FFF_FFFF, 32'h1,          64'h0000_0000_8000_0000, 5'b01010, 1};
        tbl[1]  = '{4'd1, 4'd1, 32'h8000_0001, 32'h1,          64'h0000_0000_4000_0000, 5'b10000, 1};
        tbl[2]  = '{4'd1, 4'd1, 32'h8000_0001, 32'h0,          64'h0000_0000_8000_0001, 5'b00010, 1};
        tbl[3]  = '{4'd3, 4'd0, 32'hFFFF_FFFF, 32'h2,          64'h0000_0001_FFFF_FFFE, 5'b01000, 33};
        tbl[4]  = '{4'd4, 4'd0, 32'd100,       32'd7,          64'h0000_0002_0000_000E, 5'b00000, 33};
        tbl[5]  = '{4'd4, 4'd0, 32'd100,       32'd0,          64'h0000_0064_FFFF_FFFF, 5'b00011, 33};
        tbl[6]  = '{4'd0, 4'd2, 32'h0,         32'h1,          64'h0000_0000_FFFF_FFFF, 5'b10010, 1};
        tbl[7]  = '{4'd0, 4'd2, 32'h8000_0000, 32'h1,          64'h0000_0000_7FFF_FFFF, 5'b01000, 1};
        tbl[8]  = '{4'd0, 4'd0, 32'hFFFF_FFFF, 32'h1,          64'h0,                   5'b10100, 1};
        tbl[9]  = '{4'd0, 4'd3, 32'h0,         32'h5555,       64'h0000_0000_FFFF_FFFF, 5'b10010, 1};
        tbl[10] = '{4'd0, 4'd1, 32'h7FFF_FFFF, 32'h1234,       64'h0000_0000_8000_0000, 5'b01010, 1};
        tbl[11] = '{4'd1, 4'd2, 32'h8000_0018, 32'h24,         64'h0000_0000_F800_0001, 5'b10010, 1};
        tbl[12] = '{4'd1, 4'd0, 32'hC000_0000, 32'h1,          64'h0000_0000_8000_0000, 5'b10010, 1};
        tbl[13] = '{4'd1, 4'd3, 32'h4000_0001, 32'h2,          64'h0000_0000_0000_0004, 5'b10000, 1};
        tbl[14] = '{4'd2, 4'd3, 32'h0,         32'h0,          64'h0000_0000_FFFF_FFFF, 5'b00010, 1};
        tbl[15] = '{4'd2, 4'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5,  64'h0,                   5'b00100, 1};
        tbl[16] = '{4'd2, 4'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0,  64'h0000_0000_00F0_00F0, 5'b00000, 1};
        tbl[17] = '{4'd5, 4'd0, 32'hFFFF_FFFF, 32'h1,          64'h0,                   5'b00100, 1};
        tbl[18] = '{4'd3, 4'd0, 32'h0,         32'h1234_5678,  64'h0,                   5'b00100, 33};
        tbl[19] = '{4'd0, 4'd9, 32'd5,         32'd6,          64'h0000_0000_0000_000B, 5'b00000, 1};
        tbl[20] = '{4'd4, 4'd0, 32'd5,         32'd7,          64'h0000_0005_0000_0000, 5'b00100, 33};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_state", {out, carryout, overflow, zero, N, dz, busy, done}, '0);

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].op1, tbl[i].a, tbl[i].b, r, fl, lat, bcnt);
            check($sformatf("vec%0d_result", i), {r, fl}, {tbl[i].res, tbl[i].fl});
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, (tbl[i].lat == 33) ? 32 : 0);
        end

        // start held through a multiply and its DONE cycle; accepted only once IDLE.
        @(negedge clk);
        op = 4'd3; op1 = 4'd0; in0 = 32'd3; in1 = 32'd5; start = 1'b1;
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            lat++;
            if (done) break;
            op = 4'd0; in0 = $urandom; in1 = $urandom;
        end
        check("hs_latency", lat, 33);
        check("hs_product", out, 64'd15);
        op = 4'd0; op1 = 4'd0; in0 = 32'd1; in1 = 32'd2;
        @(negedge clk);
        check("hs_done_width", {done, busy}, 2'b00);
        check("hs_hold", out, 64'd15);
        @(negedge clk);
        start = 1'b0;
        check("hs_second_start", {done, out}, {1'b1, 64'd3});
        @(negedge clk);
        check("hs_done_drop", done, 1'b0);

        // Reset in the middle of a multiply.
        run_op(4'd0, 4'd0, 32'd40, 32'd2, r, fl, lat, bcnt);
        @(negedge clk);
        op = 4'd3; op1 = 4'd0; in0 = 32'hFFFF_FFFF; in1 = 32'd2; start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("rst_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort", {out, carryout, overflow, zero, N, dz, busy, done}, '0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("rst_no_done", seen, 1'b0);
        run_op(4'd4, 4'd0, 32'd100, 32'd7, r, fl, lat, bcnt);
        check("rst_fresh_div", {r, fl}, {64'h0000_0002_0000_000E, 5'b00000});
        check("rst_fresh_latency", lat, 33);

        for (int i = 0; i < 40; i++) begin
            rop  = 4'($urandom_range(0, 5));
            rop1 = 4'($urandom_range(0, 4));
            ra   = pick();
            rb   = pick();
            model(rop, rop1, ra, rb, er, efl, elat);
            run_op(rop, rop1, ra, rb, r, fl, lat, bcnt);
            check($sformatf("rand%0d_op%0d_%0d_result", i, rop, rop1), {r, fl}, {er, efl});
            check($sformatf("rand%0d_latency", i), lat, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
